pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Central pipeline sequencer for the five-stage core. It merges per-stage stall requests into the `stall` vector consumed by every inter-stage register (pc, if_id, id_ex, ex_mem, mem_wb). It also generates `flush` and the redirect PC for MEM-stage exceptions, `eret`, and the post-TLB-write refetch. That refetch is the block's only multi-cycle sequence and is held in a small FSM.

## Interface
Parameters:
- `RESET_PC`, 32'hBFC0_0000, PC driven on `new_pc` while in reset (`new_pc_valid`=0).

Ports:
- `clk`  in  1  core clock.
- `rst`  in  1  asynchronous, active-low reset.
- `stallreq_if` / `stallreq_id` / `stallreq_ex` / `stallreq_mem`  in  1 each  stage not ready.
- `mem_excp`  in  1  MEM-stage instruction raises an exception.
- `excp_handler`  in  32  handler vector from cp0.
- `mem_eret`  in  1  MEM-stage `eret`.
- `cp0_epc`  in  32  current EPC.
- `mem_tlb_wi` / `mem_tlb_wr`  in  1 each  `tlbwi`/`tlbwr` in MEM.
- `mem_pc`  in  32  PC of the MEM-stage instruction.
- `stall`  out  6 (`Stall_t`)  bit i=1: register after stage i holds.
- `flush`  out  1  clear all pipeline registers at the next edge.
- `new_pc`  out  32  redirect target.
- `new_pc_valid`  out  1  load `new_pc` into PC at the next edge.
- `perf_stall_cycles`  out  32  cycles with any `stall` bit set.
- `perf_flush_count`  out  32  flush cycles issued.

## Operation
- FSM states: RUN, TLB_SYNC.
- Stall mapping applies only in RUN with no flush. The highest requester wins:
  - `stallreq_mem` → 6'b011111
  - `stallreq_ex` → 6'b001111
  - `stallreq_id` → 6'b000111
  - `stallreq_if` → 6'b000011
  - none → 0
  - `stall[5]` is always 0.
- Receiving registers insert a bubble where `stall[i]`=1 and `stall[i+1]`=0.
- Redirects are honoured only when `stallreq_mem`=0. While `stallreq_mem`=1 they stay pending: MEM is held, so the inputs remain stable.
- Redirect priority in RUN:
  - `mem_excp`: `flush`=1, `new_pc`=`excp_handler`.
  - else `mem_eret`: `flush`=1, `new_pc`=`cp0_epc`.
  - else `mem_tlb_wi|mem_tlb_wr`: no flush this cycle, so the TLB write advances to WB. Latch `refetch_pc` = `mem_pc`+4 (mod 2^32), go to TLB_SYNC.
- TLB_SYNC, always exactly 1 cycle:
  - The TLB write is committing from WB.
  - `flush`=1, `new_pc`=`refetch_pc`, then return to RUN.
  - Inputs in this cycle are ignored. The younger MEM instruction, including any exception it raises, is discarded and refetched.
- `new_pc_valid` equals `flush`. `stall` is 0 whenever `flush`=1.
- `new_pc` is `RESET_PC` when idle. It is never `x`.
- `tlbw*` in a branch delay slot is a software restriction and is not handled.

## Timing
- `stall`, `flush`, `new_pc`, `new_pc_valid` are combinational from state and inputs, with zero-cycle latency.
- Exception/`eret` redirect: the flush takes effect at the first edge with `stallreq_mem`=0.
- TLB refetch: the flush occurs one cycle after the `tlbw*` leaves MEM. The PC loads `refetch_pc` at the end of TLB_SYNC.
- Reset while `rst`=0, asynchronous:
  - state=RUN
  - `refetch_pc`=0
  - counters=0
  - `stall`=0, `flush`=0, `new_pc_valid`=0
- Reset in the middle of TLB_SYNC abandons the refetch.
- Simultaneous `mem_excp` and `mem_tlb_wi`: the exception wins and no TLB_SYNC follows.
- Counters wrap from 32'hFFFF_FFFF to 0.

## Configuration
- `PIPE_CTRL_PERF_EN` defined:
  - Counters increment on the rising edge after each qualifying cycle.
  - `perf_stall_cycles` counts cycles with `stall`≠0. `perf_flush_count` counts cycles with `flush`=1.
- Undefined: both outputs are constant 0, no counter flops exist, and the ports remain.

## Structure
- Shared package `cpu_defines` holds:
  - `Stall_t`, `Word_t`, `Bit_t`
  - `Pipe_ctrl_state_t` enum (RUN, TLB_SYNC)
  - constants `STALL_IF`/`STALL_ID`/`STALL_EX`/`STALL_MEM`/`STALL_NONE`
- Sub-module `pipe_perf_cnt`: a 32-bit wrapping counter with an increment enable, instantiated twice under the macro.

## Test plan
- `stallreq_ex`=1 and `stallreq_id`=1 for 3 cycles → `stall`=6'b001111 each cycle; `perf_stall_cycles` reaches 3.
- `mem_excp`=1, `excp_handler`=32'h8000_0180, with `stallreq_mem`=1 for 2 cycles, then 0:
  - → `flush`=0 for 2 cycles, then `flush`=1, `new_pc`=32'h8000_0180, `stall`=0.
- `mem_eret`=1 with `cp0_epc`=32'h8000_1000 → same-cycle `flush`=1, `new_pc`=32'h8000_1000.
- `mem_tlb_wi`=1 with `mem_pc`=32'h8000_2000:
  - → `flush`=0 that cycle;
  - next cycle state TLB_SYNC, `flush`=1, `new_pc`=32'h8000_2004;
  - then back to RUN.
- `mem_tlb_wr` and `mem_excp` in the same cycle → only the exception flush occurs; no TLB_SYNC.
- `rst` pulled low during TLB_SYNC → `flush`=0 immediately, counters 0, RUN after release.

Source files
------------

// File: rtl/cpu_defines.sv
// Shared CPU definitions: word and stall-vector types, the pipeline
// sequencer state encoding and the per-requester stall patterns.
package cpu_defines;

  typedef logic        Bit_t;
  typedef logic [31:0] Word_t;
  typedef logic [5:0]  Stall_t;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    TLB_SYNC = 1'b1
  } Pipe_ctrl_state_t;

  localparam Stall_t STALL_NONE = 6'b000000;
  localparam Stall_t STALL_IF   = 6'b000011;
  localparam Stall_t STALL_ID   = 6'b000111;
  localparam Stall_t STALL_EX   = 6'b001111;
  localparam Stall_t STALL_MEM  = 6'b011111;

  // The deepest stalling stage wins: it must also hold everything upstream.
  function automatic Stall_t stall_for(input Bit_t req_if, input Bit_t req_id,
                                       input Bit_t req_ex, input Bit_t req_mem);
    Stall_t s;
    if (req_mem)     s = STALL_MEM;
    else if (req_ex) s = STALL_EX;
    else if (req_id) s = STALL_ID;
    else if (req_if) s = STALL_IF;
    else             s = STALL_NONE;
    return s;
  endfunction

endpackage

// File: rtl/pipe_perf_cnt.sv
// 32-bit wrapping event counter with an increment enable; used for the
// optional pipeline performance counters.
module pipe_perf_cnt
  import cpu_defines::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  en,
  output Word_t count
);

  Word_t count_q;
  Word_t count_d;

  // Next count: increment on enable, natural wrap at 2^32.
  always_comb begin
    count_d = count_q;
    if (en) begin
      count_d = count_q + 32'd1;
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= 32'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: stall merging, exception/eret redirect and post-TLB-write
// refetch. Performance counters are built only when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl
  import cpu_defines::*;
#(
  parameter Word_t RESET_PC = 32'hBFC0_0000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stallreq_if,
  input  logic         stallreq_id,
  input  logic         stallreq_ex,
  input  logic         stallreq_mem,
  input  logic         mem_excp,
  input  logic [31:0]  excp_handler,
  input  logic         mem_eret,
  input  logic [31:0]  cp0_epc,
  input  logic         mem_tlb_wi,
  input  logic         mem_tlb_wr,
  input  logic [31:0]  mem_pc,
  output Stall_t       stall,
  output logic         flush,
  output logic [31:0]  new_pc,
  output logic         new_pc_valid,
  output logic [31:0]  perf_stall_cycles,
  output logic [31:0]  perf_flush_count
);

  Pipe_ctrl_state_t state_q, state_d;
  Word_t            refetch_pc_q, refetch_pc_d;
  Stall_t           stall_s;
  Bit_t             flush_s;
  Word_t            new_pc_s;

  // Next state, redirect and stall decode.
  always_comb begin
    state_d      = state_q;
    refetch_pc_d = refetch_pc_q;
    stall_s      = STALL_NONE;
    flush_s      = 1'b0;
    new_pc_s     = RESET_PC;
    case (state_q)
      RUN: begin
        // A held MEM stage keeps its redirect inputs stable, so deferring is safe.
        if (!stallreq_mem) begin
          if (mem_excp) begin
            flush_s  = 1'b1;
            new_pc_s = excp_handler;
          end else if (mem_eret) begin
            flush_s  = 1'b1;
            new_pc_s = cp0_epc;
          end else if (mem_tlb_wi || mem_tlb_wr) begin
            refetch_pc_d = mem_pc + 32'd4;
            state_d      = TLB_SYNC;
          end else begin
            state_d = RUN;
          end
        end else begin
          state_d = RUN;
        end
        if (!flush_s) begin
          stall_s = stall_for(stallreq_if, stallreq_id, stallreq_ex, stallreq_mem);
        end else begin
          stall_s = STALL_NONE;
        end
      end
      TLB_SYNC: begin
        flush_s  = 1'b1;
        new_pc_s = refetch_pc_q;
        state_d  = RUN;
      end
      default: begin
        state_d = RUN;
      end
    endcase
    // Keep the pipeline quiet and the PC at the boot vector while reset is held.
    if (!rst) begin
      stall_s      = STALL_NONE;
      flush_s      = 1'b0;
      new_pc_s     = RESET_PC;
      state_d      = RUN;
      refetch_pc_d = 32'd0;
    end else begin
      state_d = state_d;
    end
  end

  // State and refetch-target registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= RUN;
      refetch_pc_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      refetch_pc_q <= refetch_pc_d;
    end
  end

  assign stall        = stall_s;
  assign flush        = flush_s;
  assign new_pc       = new_pc_s;
  assign new_pc_valid = flush_s;

`ifdef PIPE_CTRL_PERF_EN
  pipe_perf_cnt u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (|stall_s),
    .count (perf_stall_cycles)
  );

  pipe_perf_cnt u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (flush_s),
    .count (perf_flush_count)
  );
`else
  assign perf_stall_cycles = 32'd0;
  assign perf_flush_count  = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus randomized
// traffic compared against a queue-based behavioural model.
module tb_pipe_ctrl;
  import cpu_defines::*;

  localparam Word_t RST_PC = 32'hBFC0_0000;
`ifdef PIPE_CTRL_PERF_EN
  localparam bit PERF_EN = 1'b1;
`else
  localparam bit PERF_EN = 1'b0;
`endif

  logic   clk = 1'b0;
  logic   rst = 1'b0;
  logic   stallreq_if = 1'b0, stallreq_id = 1'b0, stallreq_ex = 1'b0, stallreq_mem = 1'b0;
  logic   mem_excp = 1'b0, mem_eret = 1'b0, mem_tlb_wi = 1'b0, mem_tlb_wr = 1'b0;
  Word_t  excp_handler = 32'd0, cp0_epc = 32'd0, mem_pc = 32'd0;
  Stall_t stall;
  logic   flush, new_pc_valid;
  Word_t  new_pc, perf_stall_cycles, perf_flush_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: pending refetch targets and event tallies.
  Word_t  refetch_q[$];
  Word_t  m_stall_cnt, m_flush_cnt;
  Stall_t e_stall;
  logic   e_flush;
  Word_t  e_pc;

  pipe_ctrl #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst),
    .stallreq_if(stallreq_if), .stallreq_id(stallreq_id),
    .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
    .mem_excp(mem_excp), .excp_handler(excp_handler),
    .mem_eret(mem_eret), .cp0_epc(cp0_epc),
    .mem_tlb_wi(mem_tlb_wi), .mem_tlb_wr(mem_tlb_wr), .mem_pc(mem_pc),
    .stall(stall), .flush(flush), .new_pc(new_pc), .new_pc_valid(new_pc_valid),
    .perf_stall_cycles(perf_stall_cycles), .perf_flush_count(perf_flush_count)
  );

  always #5 clk = ~clk;

  function automatic Word_t exp_cnt(input Word_t c);
    return PERF_EN ? c : 32'd0;
  endfunction

  task automatic clear_inputs();
    stallreq_if = 1'b0; stallreq_id = 1'b0; stallreq_ex = 1'b0; stallreq_mem = 1'b0;
    mem_excp = 1'b0; mem_eret = 1'b0; mem_tlb_wi = 1'b0; mem_tlb_wr = 1'b0;
    excp_handler = 32'd0; cp0_epc = 32'd0; mem_pc = 32'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    refetch_q.delete();
    m_stall_cnt = 32'd0;
    m_flush_cnt = 32'd0;
  endtask

  // Expected outputs for the current cycle, from the architectural rules.
  task automatic model_eval();
    int lvl;
    e_stall = 6'd0;
    e_flush = 1'b0;
    e_pc    = RST_PC;
    if (refetch_q.size() > 0) begin
      e_flush = 1'b1;
      e_pc    = refetch_q[0];
    end else begin
      if (!stallreq_mem && mem_excp) begin
        e_flush = 1'b1; e_pc = excp_handler;
      end else if (!stallreq_mem && mem_eret) begin
        e_flush = 1'b1; e_pc = cp0_epc;
      end
      if (!e_flush) begin
        lvl = stallreq_mem ? 5 : stallreq_ex ? 4 : stallreq_id ? 3 : stallreq_if ? 2 : 0;
        e_stall = 6'((1 << lvl) - 1);
      end
    end
  endtask

  // Effect of the clock edge on the model.
  task automatic model_commit();
    if (refetch_q.size() > 0) begin
      void'(refetch_q.pop_front());
    end else if (!stallreq_mem && !mem_excp && !mem_eret && (mem_tlb_wi || mem_tlb_wr)) begin
      refetch_q.push_back(mem_pc + 32'd4);
    end
    if (e_stall != 6'd0) m_stall_cnt = m_stall_cnt + 32'd1;
    if (e_flush)         m_flush_cnt = m_flush_cnt + 32'd1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    clear_inputs();
    mem_excp = 1'b1; excp_handler = 32'h1234_5678; stallreq_if = 1'b1;
    #1;
    n_checks++; if (stall !== 6'd0) begin n_fail++; $display("FAIL reset_stall: got %b want %b", stall, 6'd0); end
    n_checks++; if (flush !== 1'b0) begin n_fail++; $display("FAIL reset_flush: got %b want 0", flush); end
    n_checks++; if (new_pc_valid !== 1'b0) begin n_fail++; $display("FAIL reset_npv: got %b want 0", new_pc_valid); end
    n_checks++; if (new_pc !== RST_PC) begin n_fail++; $display("FAIL reset_pc: got %h want %h", new_pc, RST_PC); end
    n_checks++; if (perf_stall_cycles !== 32'd0 || perf_flush_count !== 32'd0) begin
      n_fail++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", perf_stall_cycles, perf_flush_count); end
    do_reset();
    @(negedge clk);
    n_checks++; if (new_pc !== RST_PC || flush !== 1'b0) begin
      n_fail++; $display("FAIL idle: got pc %h flush %b want %h 0", new_pc, flush, RST_PC); end
  endtask

  task automatic test_stall_priority();
    do_reset();
    stallreq_ex = 1'b1; stallreq_id = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++; if (stall !== 6'b001111) begin n_fail++; $display("FAIL stall_ex_id c%0d: got %b want %b", i, stall, 6'b001111); end
      tick();
    end
    clear_inputs();
    @(negedge clk);
    n_checks++; if (perf_stall_cycles !== exp_cnt(32'd3)) begin
      n_fail++; $display("FAIL perf_stall: got %0d want %0d", perf_stall_cycles, exp_cnt(32'd3)); end
    n_checks++; if (stall !== 6'd0) begin n_fail++; $display("FAIL stall_none: got %b want 0", stall); end
    stallreq_if = 1'b1; stallreq_mem = 1'b1;
    @(negedge clk);
    n_checks++; if (stall !== 6'b011111) begin n_fail++; $display("FAIL stall_mem: got %b want %b", stall, 6'b011111); end
    tick();
    clear_inputs();
  endtask

  task automatic test_excp_held();
    do_reset();
    mem_excp = 1'b1; excp_handler = 32'h8000_0180; stallreq_mem = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks++; if (flush !== 1'b0) begin n_fail++; $display("FAIL excp_held c%0d: got flush %b want 0", i, flush); end
      tick();
    end
    stallreq_mem = 1'b0; stallreq_ex = 1'b1;
    @(negedge clk);
    n_checks++; if (flush !== 1'b1 || new_pc_valid !== 1'b1) begin
      n_fail++; $display("FAIL excp_flush: got %b/%b want 1/1", flush, new_pc_valid); end
    n_checks++; if (new_pc !== 32'h8000_0180) begin n_fail++; $display("FAIL excp_pc: got %h want 80000180", new_pc); end
    n_checks++; if (stall !== 6'd0) begin n_fail++; $display("FAIL excp_stall: got %b want 0", stall); end
    tick();
    clear_inputs();
  endtask

  task automatic test_eret();
    do_reset();
    mem_eret = 1'b1; cp0_epc = 32'h8000_1000;
    @(negedge clk);
    n_checks++; if (flush !== 1'b1 || new_pc !== 32'h8000_1000) begin
      n_fail++; $display("FAIL eret: got flush %b pc %h want 1 80001000", flush, new_pc); end
    tick();
    clear_inputs();
  endtask

  task automatic test_tlb_refetch(input Word_t pc);
    do_reset();
    mem_tlb_wi = 1'b1; mem_pc = pc;
    @(negedge clk);
    n_checks++; if (flush !== 1'b0) begin n_fail++; $display("FAIL tlb_first: got flush %b want 0", flush); end
    tick();
    clear_inputs();
    mem_excp = 1'b1; excp_handler = 32'hDEAD_BEEF; stallreq_mem = 1'b1;
    @(negedge clk);
    n_checks++; if (flush !== 1'b1 || new_pc !== pc + 32'd4) begin
      n_fail++; $display("FAIL tlb_sync: got flush %b pc %h want 1 %h", flush, new_pc, pc + 32'd4); end
    n_checks++; if (stall !== 6'd0) begin n_fail++; $display("FAIL tlb_sync_stall: got %b want 0", stall); end
    tick();
    clear_inputs();
    @(negedge clk);
    n_checks++; if (flush !== 1'b0 || new_pc !== RST_PC) begin
      n_fail++; $display("FAIL tlb_back: got flush %b pc %h want 0 %h", flush, new_pc, RST_PC); end
    n_checks++; if (perf_flush_count !== exp_cnt(32'd1)) begin
      n_fail++; $display("FAIL perf_flush: got %0d want %0d", perf_flush_count, exp_cnt(32'd1)); end
  endtask

  task automatic test_tlb_vs_excp();
    do_reset();
    mem_tlb_wr = 1'b1; mem_excp = 1'b1; excp_handler = 32'h8000_0200; mem_pc = 32'h8000_3000;
    @(negedge clk);
    n_checks++; if (flush !== 1'b1 || new_pc !== 32'h8000_0200) begin
      n_fail++; $display("FAIL tlb_excp: got flush %b pc %h want 1 80000200", flush, new_pc); end
    tick();
    clear_inputs();
    @(negedge clk);
    n_checks++; if (flush !== 1'b0) begin n_fail++; $display("FAIL tlb_excp_nosync: got flush %b want 0", flush); end
  endtask

  task automatic test_reset_in_sync();
    do_reset();
    mem_tlb_wi = 1'b1; mem_pc = 32'h8000_4000;
    tick();
    clear_inputs();
    @(negedge clk);
    n_checks++; if (flush !== 1'b1) begin n_fail++; $display("FAIL rsync_pre: got flush %b want 1", flush); end
    #2 rst = 1'b0;
    #1;
    n_checks++; if (flush !== 1'b0 || new_pc_valid !== 1'b0) begin
      n_fail++; $display("FAIL rsync_flush: got %b/%b want 0/0", flush, new_pc_valid); end
    n_checks++; if (perf_stall_cycles !== 32'd0 || perf_flush_count !== 32'd0) begin
      n_fail++; $display("FAIL rsync_cnt: got %0d/%0d want 0/0", perf_stall_cycles, perf_flush_count); end
    tick();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks++; if (flush !== 1'b0 || new_pc !== RST_PC) begin
        n_fail++; $display("FAIL rsync_run c%0d: got flush %b pc %h want 0 %h", i, flush, new_pc, RST_PC); end
      tick();
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      stallreq_if  = ($urandom_range(3) == 0);
      stallreq_id  = ($urandom_range(3) == 0);
      stallreq_ex  = ($urandom_range(3) == 0);
      stallreq_mem = ($urandom_range(3) == 0);
      mem_excp     = ($urandom_range(7) == 0);
      mem_eret     = ($urandom_range(7) == 0);
      mem_tlb_wi   = ($urandom_range(5) == 0);
      mem_tlb_wr   = ($urandom_range(5) == 0);
      excp_handler = $urandom;
      cp0_epc      = $urandom;
      mem_pc       = ($urandom_range(7) == 0) ? 32'hFFFF_FFFC : $urandom;
      @(negedge clk);
      model_eval();
      n_checks++; if (stall !== e_stall || flush !== e_flush || new_pc_valid !== e_flush || new_pc !== e_pc) begin
        n_fail++;
        $display("FAIL rand c%0d: got stall %b flush %b npv %b pc %h want %b %b %b %h",
                 i, stall, flush, new_pc_valid, new_pc, e_stall, e_flush, e_flush, e_pc);
      end
      n_checks++; if (perf_stall_cycles !== exp_cnt(m_stall_cnt) || perf_flush_count !== exp_cnt(m_flush_cnt)) begin
        n_fail++;
        $display("FAIL rand_cnt c%0d: got %0d/%0d want %0d/%0d", i, perf_stall_cycles, perf_flush_count,
                 exp_cnt(m_stall_cnt), exp_cnt(m_flush_cnt));
      end
      @(posedge clk);
      model_commit();
      #1;
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_stall_priority();
    test_excp_held();
    test_eret();
    test_tlb_refetch(32'h8000_2000);
    test_tlb_refetch(32'hFFFF_FFFC);
    test_tlb_vs_excp();
    test_reset_in_sync();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
